// File: rtl/scanline_double_buffer.sv
// Ping-pong scanline buffer: drawer fills the back bank, the display reads the front bank.
// Optional overrun counter enabled by defining SCANLINE_OVERRUN_CNT_EN.
module scanline_double_buffer #(
    parameter int H_RES       = 640,
    parameter int X_WIDTH     = 10,
    parameter int COLOR_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   btn_rst,
    input  logic                   line_start,
    input  logic                   wr_en,
    input  logic [X_WIDTH-1:0]     wr_x,
    input  logic [COLOR_DEPTH-1:0] wr_color,
    input  logic                   draw_done,
    output logic                   draw_req,
    input  logic                   rd_en,
    input  logic [X_WIDTH-1:0]     rd_x,
    input  logic [COLOR_DEPTH-1:0] bg_color,
    output logic [COLOR_DEPTH-1:0] rd_color,
    output logic [15:0]            overrun_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAWING = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    localparam logic [X_WIDTH:0] H_RES_W = (X_WIDTH+1)'(H_RES);

    state_t                   state_r;
    logic                     front_r;
    logic                     draw_req_r;
    logic [COLOR_DEPTH-1:0]   rd_color_r;
    logic [COLOR_DEPTH-1:0]   bank0_r [H_RES];
    logic [COLOR_DEPTH-1:0]   bank1_r [H_RES];
    logic [H_RES-1:0]         flag0_r;
    logic [H_RES-1:0]         flag1_r;

    logic                     wr_in_range_s;
    logic                     rd_in_range_s;
    logic [X_WIDTH-1:0]       wr_idx_s;
    logic [X_WIDTH-1:0]       rd_idx_s;
    logic                     back_flag_s;
    logic                     front_flag_s;
    logic [COLOR_DEPTH-1:0]   front_data_s;
    logic                     swap_s;
    logic                     overrun_s;
    logic                     wr_ok_s;

    // Decode swap/overrun events and write acceptance; indices are clamped so out-of-range x never addresses the arrays.
    always_comb begin
        wr_in_range_s = ({1'b0, wr_x} < H_RES_W);
        rd_in_range_s = ({1'b0, rd_x} < H_RES_W);
        wr_idx_s      = wr_in_range_s ? wr_x : {X_WIDTH{1'b0}};
        rd_idx_s      = rd_in_range_s ? rd_x : {X_WIDTH{1'b0}};
        back_flag_s   = front_r ? flag0_r[wr_idx_s] : flag1_r[wr_idx_s];
        front_flag_s  = front_r ? flag1_r[rd_idx_s] : flag0_r[rd_idx_s];
        front_data_s  = front_r ? bank1_r[rd_idx_s] : bank0_r[rd_idx_s];
        swap_s        = line_start && ((state_r == ST_READY) ||
                                       ((state_r == ST_DRAWING) && draw_done));
        overrun_s     = line_start && (state_r == ST_DRAWING) && !draw_done;
        wr_ok_s       = (state_r == ST_DRAWING) && !swap_s && wr_en && wr_in_range_s &&
                        (wr_color != {COLOR_DEPTH{1'b0}}) && !back_flag_s;
    end

    // Line-level state machine: bank selection and draw request pulse.
    always_ff @(posedge clk) begin
        if (!btn_rst) begin
            state_r    <= ST_IDLE;
            front_r    <= 1'b0;
            draw_req_r <= 1'b0;
        end else begin
            draw_req_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (line_start) begin
                        state_r    <= ST_DRAWING;
                        draw_req_r <= 1'b1;
                    end
                end
                ST_DRAWING: begin
                    if (swap_s) begin
                        front_r    <= ~front_r;
                        draw_req_r <= 1'b1;
                    end else if (draw_done) begin
                        state_r <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (swap_s) begin
                        front_r    <= ~front_r;
                        draw_req_r <= 1'b1;
                        state_r    <= ST_DRAWING;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Written flags: the outgoing front bank becomes the new back bank and starts empty.
    always_ff @(posedge clk) begin
        if (!btn_rst) begin
            flag0_r <= {H_RES{1'b0}};
            flag1_r <= {H_RES{1'b0}};
        end else if (swap_s) begin
            if (front_r) begin
                flag1_r <= {H_RES{1'b0}};
            end else begin
                flag0_r <= {H_RES{1'b0}};
            end
        end else if (wr_ok_s) begin
            if (front_r) begin
                flag0_r[wr_idx_s] <= 1'b1;
            end else begin
                flag1_r[wr_idx_s] <= 1'b1;
            end
        end
    end

    // Pixel storage; left unreset because the flags decide validity.
    always_ff @(posedge clk) begin
        if (wr_ok_s && front_r) begin
            bank0_r[wr_idx_s] <= wr_color;
        end else if (wr_ok_s) begin
            bank1_r[wr_idx_s] <= wr_color;
        end
    end

    // Registered read port from the front bank.
    always_ff @(posedge clk) begin
        if (!btn_rst) begin
            rd_color_r <= {COLOR_DEPTH{1'b0}};
        end else if (rd_en && rd_in_range_s) begin
            rd_color_r <= front_flag_s ? front_data_s : bg_color;
        end else begin
            rd_color_r <= {COLOR_DEPTH{1'b0}};
        end
    end

`ifdef SCANLINE_OVERRUN_CNT_EN
    logic [15:0] overrun_cnt_r;

    // Saturating count of line starts that found the back bank unfinished.
    always_ff @(posedge clk) begin
        if (!btn_rst) begin
            overrun_cnt_r <= 16'h0000;
        end else if (overrun_s && (overrun_cnt_r != 16'hFFFF)) begin
            overrun_cnt_r <= overrun_cnt_r + 16'h0001;
        end
    end

    assign overrun_count = overrun_cnt_r;
`else
    logic unused_overrun_s;
    assign unused_overrun_s = overrun_s;
    assign overrun_count    = 16'h0000;
`endif

    assign draw_req = draw_req_r;
    assign rd_color = rd_color_r;

endmodule

// File: tb/tb_scanline_double_buffer.sv
// Directed bench for scanline_double_buffer; read data is checked through a scoreboard queue.
module tb_scanline_double_buffer;

    logic        clk = 1'b0;
    logic        btn_rst = 1'b0;
    logic        line_start = 1'b0;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_x = 10'd0;
    logic [7:0]  wr_color = 8'h00;
    logic        draw_done = 1'b0;
    logic        draw_req;
    logic        rd_en = 1'b0;
    logic [9:0]  rd_x = 10'd0;
    logic [7:0]  bg_color = 8'h05;
    logic [7:0]  rd_color;
    logic [15:0] overrun_count;

    logic        rd_chk = 1'b0;
    logic [7:0]  exp_q [$];
    int          total = 0;
    int          bad = 0;

`ifdef SCANLINE_OVERRUN_CNT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    scanline_double_buffer dut (
        .clk(clk), .btn_rst(btn_rst), .line_start(line_start),
        .wr_en(wr_en), .wr_x(wr_x), .wr_color(wr_color),
        .draw_done(draw_done), .draw_req(draw_req),
        .rd_en(rd_en), .rd_x(rd_x), .bg_color(bg_color),
        .rd_color(rd_color), .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: a read issued in a cycle is compared on the following negedge.
    initial begin
        forever begin
            @(posedge clk);
            if (rd_chk) begin
                @(negedge clk);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_color: got %h with no expected entry queued", rd_color);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rd_color !== e) begin
                        bad++;
                        $display("FAIL rd_color: got %h expected %h at t=%0t", rd_color, e, $time);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ovr(input int n);
        return OVR_EN ? 16'(n) : 16'h0000;
    endfunction

    task automatic rd(input logic [9:0] x, input logic en, input logic [7:0] e);
        rd_en = en; rd_x = x; rd_chk = 1'b1;
        exp_q.push_back(e);
        tick();
        rd_chk = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wr(input logic [9:0] x, input logic [7:0] c);
        wr_en = 1'b1; wr_x = x; wr_color = c;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_done();
        draw_done = 1'b1; tick(); draw_done = 1'b0;
    endtask

    task automatic pulse_ls(input logic exp_req, input string name);
        line_start = 1'b1; tick(); line_start = 1'b0;
        check(name, {15'd0, draw_req}, {15'd0, exp_req});
    endtask

    initial begin
        repeat (3) tick();
        check("reset_rd_color", {8'd0, rd_color}, 16'h0000);
        check("reset_draw_req", {15'd0, draw_req}, 16'h0000);
        check("reset_overrun", overrun_count, 16'h0000);
        btn_rst = 1'b1;
        tick();
        // IDLE: draw_done ignored, idle write dropped
        pulse_done();
        wr(10'd7, 8'h11);
        pulse_ls(1'b1, "idle_exit_draw_req");
        tick();
        check("draw_req_one_cycle", {15'd0, draw_req}, 16'h0000);
        for (int i = 0; i < 640; i++) rd(10'(i), 1'b1, 8'h05);

        // back bank = 1
        wr(10'd10, 8'h22);
        wr(10'd10, 8'h33);
        wr(10'd20, 8'h00);
        wr(10'd640, 8'h44);
        wr(10'd5, 8'h7F);
        pulse_done();
        wr(10'd30, 8'h55);
        // swap cycle: read still sees old (empty) front, concurrent write dropped
        line_start = 1'b1; wr_en = 1'b1; wr_x = 10'd31; wr_color = 8'h56;
        rd(10'd10, 1'b1, 8'h05);
        line_start = 1'b0; wr_en = 1'b0;
        check("swap_draw_req", {15'd0, draw_req}, 16'h0001);
        rd(10'd10, 1'b1, 8'h22);
        rd(10'd11, 1'b1, 8'h05);
        rd(10'd20, 1'b1, 8'h05);
        rd(10'd0,  1'b1, 8'h05);
        rd(10'd5,  1'b1, 8'h7F);
        rd(10'd30, 1'b1, 8'h05);
        rd(10'd31, 1'b1, 8'h05);
        rd(10'd639, 1'b1, 8'h05);
        rd(10'd640, 1'b1, 8'h00);
        rd(10'd5,  1'b0, 8'h00);
        bg_color = 8'h09;
        rd(10'd11, 1'b1, 8'h09);
        check("post_swap_overrun", overrun_count, 16'h0000);

        // back bank = 0; overrun then combined done+start
        wr(10'd10, 8'h66);
        pulse_ls(1'b0, "overrun_no_req");
        check("overrun_count_1", overrun_count, ovr(1));
        rd(10'd10, 1'b1, 8'h22);
        rd(10'd5,  1'b1, 8'h7F);
        draw_done = 1'b1;
        pulse_ls(1'b1, "done_and_start_req");
        draw_done = 1'b0;
        check("overrun_stays_1", overrun_count, ovr(1));
        rd(10'd10, 1'b1, 8'h66);
        rd(10'd5,  1'b1, 8'h09);

        // back bank = 1 again (flags cleared at swap)
        wr(10'd5, 8'h7F);
        pulse_done();
        pulse_ls(1'b1, "swap3_req");
        rd(10'd5,  1'b1, 8'h7F);
        rd(10'd10, 1'b1, 8'h09);
        rd(10'd5,  1'b0, 8'h00);

        // two more overruns
        pulse_ls(1'b0, "overrun2_no_req");
        pulse_ls(1'b0, "overrun3_no_req");
        check("overrun_count_3", overrun_count, ovr(3));
        rd(10'd5, 1'b1, 8'h7F);

        // reset mid-line, coinciding with a swap-triggering line_start and a read
        pulse_done();
        btn_rst = 1'b0; line_start = 1'b1;
        rd(10'd5, 1'b1, 8'h00);
        line_start = 1'b0;
        check("midreset_draw_req", {15'd0, draw_req}, 16'h0000);
        check("midreset_overrun", overrun_count, 16'h0000);
        btn_rst = 1'b1;
        rd(10'd5, 1'b1, 8'h09);
        pulse_ls(1'b1, "after_reset_idle_exit");
        rd(10'd5, 1'b1, 8'h09);

        begin
            int guard = 0;
            while (exp_q.size() != 0 && guard < 20) begin
                tick();
                guard++;
            end
            if (exp_q.size() != 0) begin
                total++;
                bad++;
                $display("FAIL drain: %0d expected reads left, required 0", exp_q.size());
            end
        end
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scanline_double_buffer.md
# scanline_double_buffer

Ping-pong scanline buffer between the sprite drawer and the palette lookup in the display pipeline. The sprite drawer writes palette indices for the next line into the back bank while the VGA path reads the current line from the front bank at pixel rate. Banks swap on a line-start pulse, but only when the drawer has declared the back bank complete. The block enforces first-writer-wins sprite priority and transparency, fills unwritten pixels with a background index, and flags drawer overruns.

## Interface
Parameters:
- H_RES, 640, visible pixels per line (bank depth)
- X_WIDTH, 10, pixel x-coordinate width
- COLOR_DEPTH, 8, palette-index width

Ports:
- clk  in  1  pixel clock; the only clock
- btn_rst  in  1  reset, synchronous, active-low
- line_start  in  1  one-cycle pulse at start of each display line
- wr_en  in  1  drawer pixel write strobe
- wr_x  in  X_WIDTH  drawer write x-coordinate
- wr_color  in  COLOR_DEPTH  drawer palette index; 0 = transparent
- draw_done  in  1  one-cycle pulse, back bank complete
- draw_req  out  1  one-cycle pulse, drawer may start next line
- rd_en  in  1  display-enable (de) qualifier
- rd_x  in  X_WIDTH  read x-coordinate (sx_next)
- bg_color  in  COLOR_DEPTH  index returned for unwritten pixels
- rd_color  out  COLOR_DEPTH  registered pixel index to palette
- overrun_count  out  16  saturating count of missed swaps

## Operation
- Storage: two banks of H_RES x COLOR_DEPTH, plus an H_RES-bit written-flag vector per bank. `front` selects the read bank; the back bank is the other one.
- States:
  - IDLE (after reset): line_start -> DRAWING, pulse draw_req, no swap.
  - DRAWING: the back bank accepts writes.
    - draw_done -> READY.
    - line_start without draw_done -> stay in DRAWING, no swap, overrun_count +1 (saturates at 16'hFFFF), front bank re-displayed unchanged.
  - READY: writes ignored. line_start -> toggle front, clear all written flags of the new back bank in the same edge, pulse draw_req, go to DRAWING.
- draw_done and line_start in the same cycle while in DRAWING: treated as READY; swap occurs, no overrun.
- draw_done outside DRAWING is ignored.
- Write acceptance requires all of the following: state DRAWING, wr_en=1, wr_x < H_RES, wr_color != 0, and the written flag for wr_x clear. On acceptance, store wr_color and set the flag. Any other write is dropped silently (lower OAM index drawn first wins).
- Write in the same cycle as a swap-triggering line_start: dropped.
- Read: if rd_en=1 and rd_x < H_RES, then rd_color <= (front flag[rd_x] ? front data[rd_x] : bg_color). Otherwise rd_color <= 0.
- A mid-operation reset returns the block to IDLE. The currently selected bank's contents are treated as empty because all flags are cleared.

## Timing
- Reset values: rd_color=0, draw_req=0, overrun_count=0, state=IDLE, front=0, all written flags=0.
- Read latency is 1 cycle: rd_x presented at cycle n produces rd_color valid after edge n+1.
- Swap takes effect at the edge sampling line_start. A read presented in the line_start cycle uses the old front; later reads use the new front.
- draw_req is registered and high for exactly the cycle after the swap-triggering (or IDLE-exit) line_start.
- A write accepted at cycle n is visible to reads only after the following swap.
- The bg_color change affects reads sampled on or after the change; it is not latched per line.
- Throughput: one write and one read per cycle, independent banks, no stalls.

## Configuration
- SCANLINE_OVERRUN_CNT_EN defined: overrun_count is implemented as described.
- SCANLINE_OVERRUN_CNT_EN undefined: the counter is removed and overrun_count is tied to 16'h0. Swap and hold behaviour is unchanged.

## Test plan
- Reset, then line_start: draw_req pulses once 1 cycle later. Reads at x=0..639 with bg_color=8'h05 all return 8'h05.
- Write (x=10, 8'h22) then (x=10, 8'h33), draw_done, line_start: read x=10 returns 8'h22 and read x=11 returns bg_color.
- Write wr_color=0 at x=20, and write x=640 with 8'h44, then swap: x=20 returns bg_color and no array corruption occurs (x=0 returns bg).
- line_start while in DRAWING without draw_done: no swap, front bank re-read identical, overrun_count=1. Then draw_done + line_start in the same cycle: swap, overrun_count stays 1.
- rd_en=0 at x=5 (written 8'h7F): rd_color=0. Assert btn_rst=0 mid-line: next cycle rd_color=0, draw_req=0, overrun_count=0, and a subsequent read returns bg_color.
- With the macro undefined: force 3 overruns; overrun_count stays 16'h0 and swap behaviour matches the macro-defined run.
